// File: rtl/dcache_pkg.sv
// Shared types and default widths for the direct-mapped write-through data-cache controller.
// Pure definitions: no logic, no latency, no flow control.
package dcache_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_INDEX_W  = 5;
    localparam int DEF_OFFSET_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WRITE_MEM = 2'b01,
        READ_MEM  = 2'b10,
        FLUSH     = 2'b11
    } state_e;

    // Plain vector encodings of the state enum, used for the state register
    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_WRITE_MEM = WRITE_MEM;
    localparam logic [1:0] ST_READ_MEM  = READ_MEM;
    localparam logic [1:0] ST_FLUSH     = FLUSH;

endpackage

// File: rtl/dcache_if.sv
// Core-side request, cache data-array strobes and data-memory handshake of the cache controller.
// Bundle only: no latency; the core holds requests while stall is high, memory completes on mem_ready.
interface dcache_if #(
    parameter int ADDR_W  = dcache_pkg::DEF_ADDR_W,
    parameter int INDEX_W = dcache_pkg::DEF_INDEX_W
) ();
    logic               rd_en;
    logic               wr_en;
    logic [ADDR_W-1:0]  address;
    logic               flush;
    logic               stall;
    logic               hit;
    logic               cache_wr_en;
    logic               fill_en;
    logic [INDEX_W-1:0] cache_index;
    logic               mem_rd_en;
    logic               mem_wr_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;

    // Core and memory side
    modport master (
        output rd_en, wr_en, address, flush, mem_ready,
        input  stall, hit, cache_wr_en, fill_en, cache_index, mem_rd_en, mem_wr_en, mem_addr
    );

    // Cache controller side
    modport slave (
        input  rd_en, wr_en, address, flush, mem_ready,
        output stall, hit, cache_wr_en, fill_en, cache_index, mem_rd_en, mem_wr_en, mem_addr
    );
endinterface

// File: rtl/dcache_tag_store.sv
// Tag and valid arrays: one combinational lookup port, one set port, one invalidate port.
// Lookup is zero-latency; writes land on the next rising edge; no backpressure.
module dcache_tag_store #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic               o_rd_vld,
    input  logic               i_set_en,
    input  logic [INDEX_W-1:0] i_set_idx,
    input  logic [TAG_W-1:0]   i_set_tag,
    input  logic               i_inv_en,
    input  logic [INDEX_W-1:0] i_inv_idx
);
    localparam int DEPTH = 2 ** INDEX_W;

    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [DEPTH-1:0] r_vld;

    // Tags need no reset: a line's tag is only looked at while its valid bit is set
    always_ff @(posedge clk) begin
        if (i_set_en) begin
            r_tag[i_set_idx] <= i_set_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            if (i_set_en) begin
                r_vld[i_set_idx] <= 1'b1;
            end
            if (i_inv_en) begin
                r_vld[i_inv_idx] <= 1'b0;
            end
        end
    end

    assign o_rd_tag = r_tag[i_rd_idx];
    assign o_rd_vld = r_vld[i_rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller with read-miss refill and flush.
// Read hit 0 cycles; miss/write stall until mem_ready; flush takes DEPTH cycles; stall is combinational.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic     clk,
    input  logic     reset_n,
    dcache_if.slave  bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int DEPTH = 2 ** INDEX_W;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [INDEX_W-1:0] r_cnt;
    logic               r_flush_pend;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic [TAG_W-1:0]   w_line_tag;
    logic               w_line_vld;
    logic               w_idle;
    logic               w_flush_go;
    logic               w_hit;
    logic               w_fill;
    logic               w_cnt_last;
    logic               w_unused_ok;

    assign w_idx      = bus.address[OFFSET_W +: INDEX_W];
    assign w_tag      = bus.address[ADDR_W-1 -: TAG_W];
    assign w_req_idx  = r_req_addr[OFFSET_W +: INDEX_W];
    assign w_req_tag  = r_req_addr[ADDR_W-1 -: TAG_W];
    assign w_idle     = (r_state == ST_IDLE);
    assign w_flush_go = bus.flush | r_flush_pend;
    assign w_fill     = (r_state == ST_READ_MEM) & bus.mem_ready;
    assign w_cnt_last = (r_cnt == INDEX_W'(DEPTH - 1));
    assign w_unused_ok = ^bus.address[OFFSET_W-1:0];

    dcache_tag_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_store (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_rd_idx  (w_idx),
        .o_rd_tag  (w_line_tag),
        .o_rd_vld  (w_line_vld),
        .i_set_en  (w_fill),
        .i_set_idx (w_req_idx),
        .i_set_tag (w_req_tag),
        .i_inv_en  (r_state == ST_FLUSH),
        .i_inv_idx (r_cnt)
    );

    assign w_hit = w_idle & (bus.rd_en | bus.wr_en) & w_line_vld & (w_line_tag == w_tag);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_flush_go) begin
                    w_state_nxt = ST_FLUSH;
                end else if (bus.wr_en) begin
                    w_state_nxt = ST_WRITE_MEM;
                end else if (bus.rd_en && !w_hit) begin
                    w_state_nxt = ST_READ_MEM;
                end
            end
            ST_WRITE_MEM, ST_READ_MEM: begin
                if (bus.mem_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_req_addr   <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle && !w_flush_go && (bus.wr_en || (bus.rd_en && !w_hit))) begin
                r_req_addr <= bus.address;
            end
            if (w_idle && w_flush_go) begin
                r_cnt <= '0;
            end else if (r_state == ST_FLUSH) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A flush seen while busy is remembered once and replayed on return to IDLE
            if (w_idle) begin
                if (w_flush_go) begin
                    r_flush_pend <= 1'b0;
                end
            end else if (bus.flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.cache_index = '0;
        case (r_state)
            ST_IDLE:     bus.cache_index = w_idx;
            ST_READ_MEM: bus.cache_index = w_req_idx;
            ST_FLUSH:    bus.cache_index = r_cnt;
            default:     bus.cache_index = '0;
        endcase
    end

    assign bus.hit         = w_hit;
    assign bus.stall       = (w_idle & (w_flush_go | bus.wr_en | (bus.rd_en & ~w_hit)))
                           | (((r_state == ST_WRITE_MEM) | (r_state == ST_READ_MEM)) & ~bus.mem_ready)
                           | (r_state == ST_FLUSH);
    assign bus.cache_wr_en = w_idle & ~w_flush_go & bus.wr_en & w_hit;
    assign bus.fill_en     = w_fill;
    assign bus.mem_rd_en   = (r_state == ST_READ_MEM);
    assign bus.mem_wr_en   = (r_state == ST_WRITE_MEM);
    assign bus.mem_addr    = r_req_addr;

endmodule
